// File: rtl/musa_control_unit.sv
// rtl/musa_control_unit.sv - multicycle control FSM for the MUSA core
module musa_control_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic                  instr_ready,
    input  logic                  mem_ready,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_dst,
    output logic                  mem_read,
    output logic                  mem_to_reg,
    output logic [2:0]            alu_op,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            data_a_s,
    output logic [1:0]            data_b_s,
    output logic [2:0]            pc_src,
    output logic                  push,
    output logic                  pop,
    output logic                  flag_write,
    output logic                  halted
);

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_ADDI   = 6'h01;
    localparam logic [5:0] OP_SUBI   = 6'h02;
    localparam logic [5:0] OP_ANDI   = 6'h03;
    localparam logic [5:0] OP_ORI    = 6'h04;
    localparam logic [5:0] OP_LW     = 6'h05;
    localparam logic [5:0] OP_SW     = 6'h06;
    localparam logic [5:0] OP_CMP    = 6'h07;
    localparam logic [5:0] OP_JPC    = 6'h08;
    localparam logic [5:0] OP_BRFL   = 6'h09;
    localparam logic [5:0] OP_JR     = 6'h0A;
    localparam logic [5:0] OP_CALL   = 6'h0B;
    localparam logic [5:0] OP_RET    = 6'h0C;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t     state_q;
    logic [5:0] opcode_q;

    // Only the opcode field is consumed; the rest of the word belongs to the datapath.
    logic instr_unused;
    assign instr_unused = ^instruction[DATA_WIDTH-7:0];

    // Opcodes that finish through a WB cycle (CMP uses WB only as its commit cycle).
    logic has_wb;
    assign has_wb = (opcode_q == OP_R_TYPE) || (opcode_q == OP_ADDI) ||
                    (opcode_q == OP_SUBI)   || (opcode_q == OP_ANDI) ||
                    (opcode_q == OP_ORI)    || (opcode_q == OP_CMP);

    // Sequencer: state and latched opcode, with next-state folded into the register block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= 6'h00;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (instr_ready) begin
                        opcode_q <= instruction[DATA_WIDTH-1 -: 6];
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: state_q <= (opcode_q == OP_HALT) ? S_HALT : S_EXEC;
                S_EXEC: begin
                    if ((opcode_q == OP_LW) || (opcode_q == OP_SW)) begin
                        state_q <= S_MEM;
                    end else if (has_wb) begin
                        state_q <= S_WB;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_q <= (opcode_q == OP_LW) ? S_WB : S_FETCH;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Control decode from state and latched opcode; reset forces every output low at once.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = 3'b000;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        data_a_s   = 2'b00;
        data_b_s   = 2'b00;
        pc_src     = 3'b000;
        push       = 1'b0;
        pop        = 1'b0;
        flag_write = 1'b0;
        halted     = 1'b0;

        // Operand and next-PC selects are held from EXEC through the last state.
        if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
            case (opcode_q)
                OP_R_TYPE: begin
                    reg_dst = 1'b1; alu_op = 3'b010; data_a_s = 2'b10; data_b_s = 2'b01; pc_src = 3'b010;
                end
                OP_ADDI: begin alu_op = 3'b000; data_a_s = 2'b10; pc_src = 3'b010; end
                OP_SUBI: begin alu_op = 3'b001; data_a_s = 2'b10; pc_src = 3'b010; end
                OP_ANDI: begin alu_op = 3'b011; data_a_s = 2'b10; pc_src = 3'b010; end
                OP_ORI:  begin alu_op = 3'b100; data_a_s = 2'b10; pc_src = 3'b010; end
                OP_LW:   begin alu_op = 3'b000; data_a_s = 2'b10; pc_src = 3'b010; end
                OP_SW:   begin alu_op = 3'b000; data_a_s = 2'b10; pc_src = 3'b010; end
                OP_CMP: begin
                    alu_op = 3'b001; data_a_s = 2'b10; data_b_s = 2'b01; pc_src = 3'b010;
                end
                OP_JPC:  begin data_b_s = 2'b10; pc_src = 3'b100; end
                OP_BRFL: begin alu_op = 3'b101; data_a_s = 2'b10; pc_src = 3'b001; end
                OP_JR:   pc_src = 3'b001;
                OP_CALL: pc_src = 3'b001;
                OP_RET:  pc_src = 3'b000;
                default: pc_src = 3'b010;
            endcase
        end

        case (state_q)
            S_FETCH: ir_write = instr_ready;
            S_EXEC: begin
                flag_write = (opcode_q == OP_CMP);
                push       = (opcode_q == OP_CALL);
                pop        = (opcode_q == OP_RET);
                pc_write   = !has_wb && (opcode_q != OP_LW) && (opcode_q != OP_SW);
            end
            S_MEM: begin
                mem_read  = (opcode_q == OP_LW);
                mem_write = (opcode_q == OP_SW);
                pc_write  = (opcode_q == OP_SW) && mem_ready;
            end
            S_WB: begin
                reg_write  = (opcode_q != OP_CMP);
                mem_to_reg = (opcode_q == OP_LW);
                pc_write   = 1'b1;
            end
            S_HALT: begin
                pc_src = 3'b110;
                halted = 1'b1;
            end
            default: ;
        endcase

        if (rst) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_read   = 1'b0;
            mem_to_reg = 1'b0;
            alu_op     = 3'b000;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            data_a_s   = 2'b00;
            data_b_s   = 2'b00;
            pc_src     = 3'b000;
            push       = 1'b0;
            pop        = 1'b0;
            flag_write = 1'b0;
            halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_musa_control_unit.sv
// tb/tb_musa_control_unit.sv - scoreboard bench for musa_control_unit
`timescale 1ns/1ps
module tb_musa_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        instr_ready = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_write, pc_write, reg_dst, mem_read, mem_to_reg;
    logic [2:0]  alu_op;
    logic        mem_write, reg_write;
    logic [1:0]  data_a_s, data_b_s;
    logic [2:0]  pc_src;
    logic        push, pop, flag_write, halted;

    musa_control_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_ready(instr_ready),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .reg_dst(reg_dst),
        .mem_read(mem_read), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .mem_write(mem_write),
        .reg_write(reg_write), .data_a_s(data_a_s), .data_b_s(data_b_s), .pc_src(pc_src),
        .push(push), .pop(pop), .flag_write(flag_write), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       reg_dst;
        logic       mem_read;
        logic       mem_to_reg;
        logic [2:0] alu_op;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] a_s;
        logic [1:0] b_s;
        logic [2:0] pc_src;
        logic       push;
        logic       pop;
        logic       flag_write;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic        rst;
        logic        ir;
        logic        mr;
        logic [31:0] instr;
        ctl_t        exp;
        logic [5:0]  op;
    } item_t;

    item_t      stim[$];
    ctl_t       sb_q[$];
    logic [5:0] sb_op[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    function automatic item_t mk(input logic r, input logic ir, input logic mr,
                                 input logic [31:0] w, input ctl_t e, input logic [5:0] op);
        item_t it;
        it.rst = r; it.ir = ir; it.mr = mr; it.instr = w; it.exp = e; it.op = op;
        return it;
    endfunction

    // Selects the opcode holds from EXEC to the end of the instruction.
    function automatic ctl_t body_ctl(input logic [5:0] op);
        ctl_t c = '0;
        case (op)
            6'h00: begin c.reg_dst = 1; c.alu_op = 3'd2; c.a_s = 2; c.b_s = 1; c.pc_src = 3'd2; end
            6'h01: begin c.alu_op = 3'd0; c.a_s = 2; c.pc_src = 3'd2; end
            6'h02: begin c.alu_op = 3'd1; c.a_s = 2; c.pc_src = 3'd2; end
            6'h03: begin c.alu_op = 3'd3; c.a_s = 2; c.pc_src = 3'd2; end
            6'h04: begin c.alu_op = 3'd4; c.a_s = 2; c.pc_src = 3'd2; end
            6'h05, 6'h06: begin c.alu_op = 3'd0; c.a_s = 2; c.pc_src = 3'd2; end
            6'h07: begin c.alu_op = 3'd1; c.a_s = 2; c.b_s = 1; c.pc_src = 3'd2; end
            6'h08: begin c.b_s = 2; c.pc_src = 3'd4; end
            6'h09: begin c.alu_op = 3'd5; c.a_s = 2; c.pc_src = 3'd1; end
            6'h0A, 6'h0B: c.pc_src = 3'd1;
            6'h0C: c.pc_src = 3'd0;
            default: c.pc_src = 3'd2;
        endcase
        return c;
    endfunction

    function automatic ctl_t reset_ctl();
        ctl_t c = '0;
        return c;
    endfunction

    task automatic add_reset();
        stim.push_back(mk(1'b1, 1'($urandom), 1'($urandom), $urandom, reset_ctl(), 6'h00));
    endtask

    // One instruction as a list of cycles; abort_at >= 0 replaces that cycle with a reset.
    task automatic gen(input logic [31:0] word, input int idle, input int stalls, input int abort_at);
        item_t      q[$];
        ctl_t       e;
        ctl_t       b;
        logic [5:0] op = word[31:26];
        bit         is_mem = (op == 6'h05) || (op == 6'h06);
        bit         is_wb  = (op <= 6'h05) || (op == 6'h07);
        b = body_ctl(op);
        for (int i = 0; i < idle; i++)
            q.push_back(mk(1'b0, 1'b0, 1'($urandom), $urandom, reset_ctl(), op));
        e = '0; e.ir_write = 1;
        q.push_back(mk(1'b0, 1'b1, 1'($urandom), word, e, op));
        q.push_back(mk(1'b0, 1'($urandom), 1'($urandom), $urandom, reset_ctl(), op));
        if (op != 6'h3F) begin
            e = b;
            e.flag_write = (op == 6'h07);
            e.push       = (op == 6'h0B);
            e.pop        = (op == 6'h0C);
            e.pc_write   = !is_mem && !is_wb;
            q.push_back(mk(1'b0, 1'($urandom), 1'($urandom), $urandom, e, op));
            if (is_mem) begin
                e = b;
                e.mem_read  = (op == 6'h05);
                e.mem_write = (op == 6'h06);
                for (int i = 0; i < stalls; i++)
                    q.push_back(mk(1'b0, 1'($urandom), 1'b0, $urandom, e, op));
                e.pc_write = (op == 6'h06);
                q.push_back(mk(1'b0, 1'($urandom), 1'b1, $urandom, e, op));
            end
            if (is_wb) begin
                e = b;
                e.reg_write  = (op != 6'h07);
                e.mem_to_reg = (op == 6'h05);
                e.pc_write   = 1;
                q.push_back(mk(1'b0, 1'($urandom), 1'($urandom), $urandom, e, op));
            end
        end
        foreach (q[i]) begin
            if (i == abort_at) begin
                add_reset();
                return;
            end
            stim.push_back(q[i]);
        end
    endtask

    // Monitor: every sampled cycle pops the next expected control vector.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            ctl_t       exp_v;
            ctl_t       act;
            logic [5:0] op;
            exp_v = sb_q.pop_front();
            op    = sb_op.pop_front();
            act = {ir_write, pc_write, reg_dst, mem_read, mem_to_reg, alu_op, mem_write,
                   reg_write, data_a_s, data_b_s, pc_src, push, pop, flag_write, halted};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL ctl op=%h cycle=%0d actual=%h required=%h", op, cyc, act, exp_v);
            end
        end
    end

    initial begin
        logic [5:0] pool[15];
        ctl_t       h;
        pool = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h15, 6'h3E};

        add_reset();
        add_reset();
        gen(32'h00000020, 1, 0, -1);
        gen({6'h05, 26'($urandom)}, 0, 3, -1);
        gen({6'h0B, 26'($urandom)}, 0, 0, -1);
        gen({6'h0C, 26'($urandom)}, 0, 0, -1);
        gen({6'h09, 26'($urandom)}, 0, 0, -1);
        gen({6'h08, 26'($urandom)}, 0, 0, -1);
        gen({6'h05, 26'($urandom)}, 0, 3, 4);
        gen({6'h06, 26'($urandom)}, 0, 0, -1);
        for (int n = 0; n < 40; n++)
            gen({pool[$urandom_range(0, 14)], 26'($urandom)}, $urandom_range(0, 2),
                $urandom_range(0, 3), -1);
        gen(32'hFC000000, 1, 0, -1);
        h = '0; h.pc_src = 3'b110; h.halted = 1;
        for (int n = 0; n < 22; n++)
            stim.push_back(mk(1'b0, 1'($urandom), 1'($urandom), $urandom, h, 6'h3F));
        add_reset();
        gen(32'h00000020, 0, 0, -1);

        @(posedge clk); #1;
        foreach (stim[i]) begin
            rst         = stim[i].rst;
            instr_ready = stim[i].ir;
            mem_ready   = stim[i].mr;
            instruction = stim[i].instr;
            sb_q.push_back(stim[i].exp);
            sb_op.push_back(stim[i].op);
            cyc = i;
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
